keypad_scan_ctrl: RTL and testbench

// - Scan sequencer for a 4x4 active-low key matrix: drives one column low at a

---
 rtl/keypad_scan_ctrl_pkg.sv | 30 +++
 rtl/keypad_scan_ctrl_sync2.sv | 26 ++
 rtl/keypad_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and helpers for the keypad scan controller.
// Row patterns are active-low: a pressed key pulls its row to 0.
package keypad_pkg;

    typedef enum logic [2:0] {
        KP_IDLE,
        KP_DRIVE,
        KP_SAMPLE,
        KP_CONFIRM,
        KP_REPORT,
        KP_HOLD
    } kp_state_e;

    // Index of the low bit in a pattern known to have exactly one 0.
    function automatic logic [1:0] row_idx(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // True when exactly one row is pulled low.
    function automatic logic one_low(input logic [3:0] r);
        return (r == 4'hE) || (r == 4'hD) ||
               (r == 4'hB) || (r == 4'h7);
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// Both stages load RST_VAL while rst is high.
module sync2 #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    // Shift the raw input through two register stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner with one time-shared debounce counter.
// Reports one code per confirmed press and waits for a stable release.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int DEB_CYC    = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = $clog2(DEB_CYC + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYC);
    localparam logic [SW-1:0] SET_MAX = SW'(SETTLE_CYC);

    kp_state_e     state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [SW-1:0] set_q, set_d;
    logic [CW-1:0] deb_q, deb_d;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    code_d;
    logic [3:0]    col_n_d;
    logic          valid_d;
    logic          held_d;
    logic [3:0]    rs;
    logic          single;
    logic          none;

    sync2 #(
        .W      (4),
        .RST_VAL(4'hF)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (row_n),
        .q  (rs)
    );

    assign single = one_low(rs);
    assign none   = (rs == 4'hF);

    // Next-state, counter and next-output decode.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        set_d   = set_q;
        deb_d   = deb_q;
        pat_d   = pat_q;
        code_d  = key_code;
        unique case (state_q)
            KP_IDLE: begin
                if (scan_en) begin
                    state_d = KP_DRIVE;
                    set_d   = '0;
                end
            end
            KP_DRIVE: begin
                if (!scan_en) begin
                    state_d = KP_IDLE;
                end else if (set_q == SET_MAX) begin
                    state_d = KP_SAMPLE;
                end else begin
                    set_d = set_q + SW'(1);
                end
            end
            KP_SAMPLE: begin
                if (!scan_en) begin
                    state_d = KP_IDLE;
                end else if (single) begin
                    pat_d   = rs;
                    deb_d   = CW'(1);
                    state_d = KP_CONFIRM;
                end else begin
                    col_d   = col_q + 2'd1;
                    set_d   = '0;
                    state_d = KP_DRIVE;
                end
            end
            KP_CONFIRM: begin
                if (!scan_en) begin
                    state_d = KP_IDLE;
                end else if (deb_q == DEB_MAX) begin
                    code_d  = {row_idx(pat_q), col_q};
                    state_d = KP_REPORT;
                end else if (rs == pat_q) begin
                    deb_d = deb_q + CW'(1);
                end else begin
                    col_d   = col_q + 2'd1;
                    set_d   = '0;
                    state_d = KP_DRIVE;
                end
            end
            KP_REPORT: begin
                deb_d   = '0;
                state_d = KP_HOLD;
            end
            KP_HOLD: begin
                if (deb_q == DEB_MAX) begin
                    col_d   = col_q + 2'd1;
                    set_d   = '0;
                    state_d = scan_en ? KP_DRIVE : KP_IDLE;
                end else if (none) begin
                    deb_d = deb_q + CW'(1);
                end else begin
                    deb_d = '0;
                end
            end
            default: begin
                state_d = KP_IDLE;
            end
        endcase
        col_n_d = (state_d == KP_IDLE) ? 4'hF : ~(4'b0001 << col_d);
        valid_d = (state_d == KP_REPORT);
        held_d  = (state_d == KP_REPORT) || (state_d == KP_HOLD);
    end

    // State, counters and registered pin/report outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= KP_IDLE;
            col_q     <= 2'd0;
            set_q     <= '0;
            deb_q     <= '0;
            pat_q     <= 4'hF;
            col_n     <= 4'hF;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            set_q     <= set_d;
            deb_q     <= deb_d;
            pat_q     <= pat_d;
            col_n     <= col_n_d;
            key_code  <= code_d;
            key_valid <= valid_d;
            key_held  <= held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: simulated key matrix, timeline model,
// directed scenarios and a randomized soak.
module tb_keypad_scan_ctrl;

    localparam int SETTLE = 2;
    localparam int DEB    = 8;
    localparam logic [15:0] K21   = 16'h0200;
    localparam logic [15:0] GHOST = 16'h2200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_en = 1'b0;
    logic [3:0] row_n = 4'hF;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = '0;
    int total = 0;
    int bad = 0;
    int nvalid = 0;
    bit chk_on = 1'b0;

    keypad_scan_ctrl #(
        .SETTLE_CYC(SETTLE),
        .DEB_CYC   (DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scan_en  (scan_en),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Physical matrix: a row reads low if any pressed key on it sits
    // on a column currently driven low.
    function automatic logic [3:0] rows_of(input logic [15:0] k,
                                           input logic [3:0] cn);
        logic [3:0] r;
        r = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (k[rr*4+cc] && !cn[cc]) r[rr] = 1'b0;
        return r;
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] s);
        for (int i = 0; i < 4; i++)
            if (!s[i]) return 2'(i);
        return 2'd0;
    endfunction

    // Timeline model: column age, run lengths of matching samples.
    bit         m_act = 0, m_cand = 0, m_valid = 0, m_held = 0;
    int         m_col = 0, m_age = 0, m_n = 0, m_rel = 0;
    logic [3:0] m_p = 4'hF, m_code = 4'h0;
    logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, s;
    logic [3:0] e_col = 4'hF;

    always @(posedge clk) begin
        s = m_s2;
        if (rst) begin
            m_act = 0; m_cand = 0; m_valid = 0; m_held = 0;
            m_col = 0; m_age = 0; m_n = 0; m_rel = 0;
            m_code = 4'h0; m_s1 = 4'hF; m_s2 = 4'hF;
        end else begin
            if (m_valid) begin
                m_valid = 0; m_held = 1; m_rel = 0;
            end else if (m_held) begin
                if (m_rel == DEB) begin
                    m_held = 0; m_col = (m_col + 1) % 4;
                    m_act = scan_en; m_age = 0;
                end else begin
                    m_rel = (s == 4'hF) ? m_rel + 1 : 0;
                end
            end else if (!m_act) begin
                if (scan_en) begin m_act = 1; m_age = 0; end
            end else if (!scan_en) begin
                m_act = 0; m_cand = 0;
            end else if (m_cand) begin
                if (m_n == DEB) begin
                    m_cand = 0; m_valid = 1;
                    m_code = {low_row(m_p), 2'(m_col)};
                end else if (s == m_p) begin
                    m_n++;
                end else begin
                    m_cand = 0; m_col = (m_col + 1) % 4; m_age = 0;
                end
            end else if (m_age <= SETTLE) begin
                m_age++;
            end else if ($countones(~s) == 1) begin
                m_cand = 1; m_p = s; m_n = 1;
            end else begin
                m_col = (m_col + 1) % 4; m_age = 0;
            end
            m_s2 = m_s1;
            m_s1 = row_n;
        end
        e_col = m_act ? ~(4'b0001 << m_col) : 4'hF;
    end

    task automatic check(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("col_n", int'(col_n), int'(e_col));
            check("key_valid", int'(key_valid), int'(m_valid));
            check("key_held", int'(key_held), int'(m_valid | m_held));
            check("key_code", int'(key_code), int'(m_code));
        end
    end

    task automatic tick();
        @(negedge clk);
        row_n = rows_of(keys, col_n);
        if (key_valid) nvalid++;
    endtask

    task automatic set_keys(input logic [15:0] k);
        keys = k;
        row_n = rows_of(keys, col_n);
    endtask

    task automatic wait_valid(input string nm);
        bit got;
        got = 0;
        for (int i = 0; i < 150 && !got; i++) begin
            tick();
            got = key_valid;
        end
        check(nm, int'(got), 1);
    endtask

    task automatic wait_col(input logic [3:0] v, input string nm);
        int i;
        i = 0;
        while (col_n == v && i < 60) begin tick(); i++; end
        while (col_n != v && i < 120) begin tick(); i++; end
        check(nm, int'(col_n), int'(v));
    endtask

    task automatic release_len(output int n);
        n = 0;
        while (key_held && n < 60) begin tick(); n++; end
    endtask

    initial begin
        int v0, n, m;
        bit sawb;
        logic [15:0] base;
        int sel;
        base = '0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("rst_col", int'(col_n), 'hF);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_code", int'(key_code), 0);
        rst = 1'b0;
        scan_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            logic [3:0] w;
            tick();
            w = ~(4'b0001 << ((i / 4) % 4));
            check("scan_seq", int'(col_n), int'(w));
        end

        // clean press of row 2 / column 1
        v0 = nvalid;
        set_keys(K21);
        wait_valid("press_to");
        check("press_code", int'(key_code), 'h9);
        check("model_code", int'(m_code), 'h9);
        check("press_held", int'(key_held), 1);
        tick();
        check("valid_pulse", int'(key_valid), 0);
        repeat (3) tick();
        check("press_once", nvalid - v0, 1);
        set_keys('0);
        release_len(n);
        check("release_lat", n, 11);
        check("resume_col", int'(col_n), 'hB);

        // bounce during confirmation
        v0 = nvalid;
        set_keys(K21);
        wait_col(4'hD, "bounce_col");
        repeat (4) tick();
        for (int h = 0; h < 8; h++) begin
            set_keys((h % 2) != 0 ? K21 : 16'h0);
            repeat (3) tick();
        end
        check("bounce_none", nvalid - v0, 0);
        wait_valid("bounce_to");
        check("bounce_code", int'(key_code), 'h9);
        check("bounce_once", nvalid - v0, 1);
        tick();
        set_keys('0);
        release_len(n);
        check("bounce_rel", n, 11);

        // ghost: two rows low on one column
        v0 = nvalid;
        set_keys(GHOST);
        wait_col(4'hD, "ghost_col");
        sawb = 0;
        repeat (12) begin
            tick();
            if (col_n == 4'hB) sawb = 1;
        end
        check("ghost_adv", int'(sawb), 1);
        repeat (20) tick();
        check("ghost_none", nvalid - v0, 0);
        set_keys('0);

        // release bounce during hold
        set_keys(K21);
        wait_valid("rb_to");
        v0 = nvalid;
        tick();
        set_keys('0);
        repeat (5) tick();
        set_keys(K21);
        tick();
        set_keys('0);
        release_len(m);
        check("rb_len", 6 + m, 17);
        check("rb_once", nvalid - v0, 0);

        // abort mid-confirm, then reset in hold
        v0 = nvalid;
        set_keys(K21);
        wait_col(4'hD, "abort_col0");
        repeat (6) tick();
        scan_en = 1'b0;
        tick();
        check("abort_col", int'(col_n), 'hF);
        check("abort_held", int'(key_held), 0);
        repeat (10) tick();
        check("abort_none", nvalid - v0, 0);
        scan_en = 1'b1;
        wait_valid("resume_to");
        check("resume_code", int'(key_code), 'h9);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("hrst_col", int'(col_n), 'hF);
        check("hrst_held", int'(key_held), 0);
        check("hrst_valid", int'(key_valid), 0);
        check("hrst_code", int'(key_code), 0);
        rst = 1'b0;
        set_keys('0);

        // randomized soak
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                sel = int'($urandom_range(0, 99));
                if (sel < 50)
                    base = '0;
                else if (sel < 85)
                    base = 16'(1) << $urandom_range(0, 15);
                else
                    base = (16'(1) << $urandom_range(0, 15)) |
                           (16'(1) << $urandom_range(0, 15));
            end
            if ($urandom_range(0, 199) == 0) scan_en = ~scan_en;
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 15) == 0)
                set_keys(base ^ (16'(1) << $urandom_range(0, 15)));
            else
                set_keys(base);
            tick();
        end
        rst = 1'b0;
        scan_en = 1'b1;
        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
